// File: rtl/conv_accumulator_if.sv
// Handshake bundle for conv_accumulator: CSA beat input side and saturated result side.
interface conv_accumulator_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned E  = 3,
    parameter int unsigned OW = 8
);
    logic          i_valid;
    logic          o_ready;
    logic [W+E-1:0] i_sum;
    logic          i_cout;
    logic [OW-1:0] i_bias;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_data;
    logic          o_sat;

    modport master (
        output i_valid, i_sum, i_cout, i_bias, i_ready,
        input  o_ready, o_valid, o_data, o_sat
    );

    modport slave (
        input  i_valid, i_sum, i_cout, i_bias, i_ready,
        output o_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/conv_accumulator.sv
// Sums C unsigned CSA beats per group, adds a per-group bias and emits a saturated result.
module conv_accumulator #(
    parameter int unsigned W  = 4,
    parameter int unsigned E  = 3,
    parameter int unsigned C  = 4,
    parameter int unsigned OW = 8
) (
    input  logic              clk,
    input  logic              rst,
    conv_accumulator_if.slave bus
);
    localparam int unsigned IW = W + E + 1;
    localparam int unsigned AW = IW + $clog2(C) + 1;
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(C - 1);

    typedef enum logic [1:0] {StAcc, StAdd, StOut} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_acc;
    logic [OW-1:0] r_bias;
    logic          r_valid;
    logic [OW-1:0] r_data;
    logic          r_sat;

    logic          w_ready;
    logic          w_accept;
    logic          w_last;
    logic [IW-1:0] w_beat;
    logic          w_sat;

    assign w_beat   = {bus.i_cout, bus.i_sum};
    assign w_accept = bus.i_valid && w_ready;
    assign w_last   = (r_cnt == LastCnt);
    // Anything above the low OW bits means the result does not fit.
    assign w_sat    = (r_acc >> OW) != '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            StAcc: begin
                w_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = StAdd;
                end
            end
            StAdd: w_state_nxt = StOut;
            StOut: begin
                if (r_valid && bus.i_ready) begin
                    w_state_nxt = StAcc;
                end
            end
            default: w_state_nxt = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StAcc;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_bias  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (r_cnt == '0) begin
                    r_acc  <= AW'(w_beat);
                    r_bias <= bus.i_bias;
                end else begin
                    r_acc <= r_acc + AW'(w_beat);
                end
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (r_state == StAdd) begin
                r_acc <= r_acc + AW'(r_bias);
            end
            // First OUT cycle registers the clipped result; it then holds until taken.
            if (r_state == StOut) begin
                if (!r_valid) begin
                    r_valid <= 1'b1;
                    r_data  <= w_sat ? {OW{1'b1}} : OW'(r_acc);
                    r_sat   <= w_sat;
                end else if (bus.i_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_sat   = r_sat;
endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: table of full groups plus hand-written corner sequences.
module tb_conv_accumulator;
    localparam int unsigned W  = 4;
    localparam int unsigned E  = 3;
    localparam int unsigned C  = 4;
    localparam int unsigned OW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_accumulator_if #(.W(W), .E(E), .OW(OW)) bus ();
    conv_accumulator_if #(.W(W), .E(E), .OW(OW)) bus1 ();

    conv_accumulator #(.W(W), .E(E), .C(C), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_accumulator #(.W(W), .E(E), .C(1), .OW(OW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        int b0, b1, b2, b3;
        int bias;
        int data;
        int sat;
    } vec_t;

    typedef struct {
        int beat;
        int bias;
        int data;
        int sat;
    } vec1_t;

    vec_t  vecs[7];
    vec1_t vecs1[4];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_beat(input int v, input int b);
        logic [7:0] val;
        val = 8'(v);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_cout  = val[7];
        bus.i_sum   = val[6:0];
        bus.i_bias  = 8'(b);
    endtask

    task automatic drive_gap();
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_sum   = 7'd77;
        bus.i_bias  = 8'd99;
    endtask

    // Called at the negedge where the last beat was driven; it is accepted on the next posedge.
    task automatic wait_result(input string name, input int exp_data, input int exp_sat);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            k++;
        end while (!bus.o_valid && k < 20);
        check({name, " latency"}, k, 3);
        check({name, " data"}, bus.o_data, exp_data);
        check({name, " sat"}, bus.o_sat, exp_sat);
    endtask

    task automatic handshake(input string name);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({name, " valid after take"}, bus.o_valid, 0);
        check({name, " ready after take"}, bus.o_ready, 1);
    endtask

    task automatic run_group(input string name, input vec_t v);
        drive_beat(v.b0, v.bias);
        drive_beat(v.b1, v.bias);
        drive_beat(v.b2, v.bias);
        drive_beat(v.b3, v.bias);
        wait_result(name, v.data, v.sat);
        handshake(name);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int seen;
        vec_t g;

        vecs[0] = '{5, 10, 3, 7, 4, 29, 0};
        vecs[1] = '{255, 255, 255, 255, 255, 255, 1};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{60, 60, 60, 60, 15, 255, 0};
        vecs[4] = '{60, 60, 60, 60, 16, 255, 1};
        vecs[5] = '{128, 1, 2, 3, 200, 255, 1};
        vecs[6] = '{100, 50, 25, 12, 0, 187, 0};
        vecs1[0] = '{10, 5, 15, 0};
        vecs1[1] = '{200, 100, 255, 1};
        vecs1[2] = '{255, 0, 255, 0};
        vecs1[3] = '{0, 255, 255, 0};

        rst = 1'b1;
        bus.i_valid = 0; bus.i_sum = 0; bus.i_cout = 0; bus.i_bias = 0; bus.i_ready = 0;
        bus1.i_valid = 0; bus1.i_sum = 0; bus1.i_cout = 0; bus1.i_bias = 0; bus1.i_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset ready", bus.o_ready, 1);
        check("reset valid", bus.o_valid, 0);
        check("reset data", bus.o_data, 0);
        check("reset sat", bus.o_sat, 0);
        check("reset c1 ready", bus1.o_ready, 1);
        check("reset c1 valid", bus1.o_valid, 0);

        for (int i = 0; i < 7; i++) begin
            run_group($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held, beat offered during OUT must not be consumed.
        g = '{5, 10, 3, 7, 4, 29, 0};
        drive_beat(g.b0, g.bias);
        drive_beat(g.b1, g.bias);
        drive_beat(g.b2, g.bias);
        drive_beat(g.b3, g.bias);
        wait_result("stall", 29, 0);
        bus.i_valid = 1'b1;
        bus.i_cout  = 1'b0;
        bus.i_sum   = 7'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d data", i), bus.o_data, 29);
            check($sformatf("stall%0d ready", i), bus.o_ready, 0);
            check($sformatf("stall%0d valid", i), bus.o_valid, 1);
        end
        bus.i_valid = 1'b0;
        handshake("stall");
        g = '{1, 2, 3, 4, 0, 10, 0};
        run_group("after stall", g);

        // Input gaps: pattern 1,0,0,1,1,0,1; later biases must be ignored.
        drive_beat(1, 20);
        drive_gap();
        drive_gap();
        drive_beat(2, 99);
        drive_beat(3, 99);
        drive_gap();
        drive_beat(4, 99);
        wait_result("gaps", 30, 0);
        handshake("gaps");

        // Reset mid-group discards the partial sum.
        drive_beat(50, 50);
        drive_beat(50, 50);
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_valid) seen = 1;
        end
        check("mid reset no output", seen, 0);
        g = '{1, 1, 1, 1, 0, 4, 0};
        run_group("after mid reset", g);

        // Reset wins over a handshake and a new beat while OUT holds a saturated result.
        g = '{255, 255, 255, 255, 255, 255, 1};
        drive_beat(g.b0, g.bias);
        drive_beat(g.b1, g.bias);
        drive_beat(g.b2, g.bias);
        drive_beat(g.b3, g.bias);
        wait_result("out reset", 255, 1);
        rst = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        check("out reset valid", bus.o_valid, 0);
        check("out reset data", bus.o_data, 0);
        check("out reset sat", bus.o_sat, 0);
        check("out reset ready", bus.o_ready, 1);
        g = '{1, 1, 1, 1, 0, 4, 0};
        run_group("after out reset", g);

        // C=1 build: every beat closes a group.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] val;
            val = 8'(vecs1[i].beat);
            @(negedge clk);
            bus1.i_valid = 1'b1;
            bus1.i_cout  = val[7];
            bus1.i_sum   = val[6:0];
            bus1.i_bias  = 8'(vecs1[i].bias);
            k = 0;
            do begin
                @(negedge clk);
                bus1.i_valid = 1'b0;
                k++;
            end while (!bus1.o_valid && k < 20);
            check($sformatf("c1 vec%0d latency", i), k, 3);
            check($sformatf("c1 vec%0d data", i), bus1.o_data, vecs1[i].data);
            check($sformatf("c1 vec%0d sat", i), bus1.o_sat, vecs1[i].sat);
            bus1.i_ready = 1'b1;
            @(negedge clk);
            bus1.i_ready = 1'b0;
            check($sformatf("c1 vec%0d ready", i), bus1.o_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
